// File: rtl/inv_shift_rows_serial.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_serial
//
// Byte-serial AES InvShiftRows engine. A 128-bit state arrives as 16 bytes in
// column-major order (byte k -> column k/4, row k%4). Each complete block is
// held in one of two ping-pong banks. It is then replayed with every row r
// rotated right by r columns. The engine sustains one byte per cycle with a
// latency of one block.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   s_valid  in   input byte valid
//   s_ready  out  engine can accept an input byte
//   s_data   in   input byte [7:0]
//   m_valid  out  output byte valid
//   m_ready  in   downstream accepts an output byte
//   m_data   out  output byte [7:0] (0x00 while m_valid is low)
//   m_last   out  high with output byte 15 of a block
//   enc      in   only with AES_SR_DUAL_DIR_EN: 1 = forward ShiftRows for the
//                 block whose byte 0 is accepted in this cycle
//
// Build option:
//   AES_SR_DUAL_DIR_EN  adds the enc port and a direction flag for each bank.
//                       Without it, the engine always applies the inverse
//                       mapping.
// -----------------------------------------------------------------------------
module inv_shift_rows_serial (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last
`ifdef AES_SR_DUAL_DIR_EN
  ,
  input  logic       enc
`endif
);

  logic [7:0] bank_q [2][16];

  logic [1:0] full_q,   full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] rd_col;
  logic [1:0] rd_row;
  logic [1:0] src_col;
  logic [3:0] rd_idx;

`ifdef AES_SR_DUAL_DIR_EN
  logic [1:0] dir_q, dir_d;
`endif

  // Both ready and valid come only from the full flags. This keeps m_ready
  // and s_ready, and also s_valid and m_valid, free of combinational paths.
  assign s_ready = !full_q[wr_sel_q];
  assign m_valid = full_q[rd_sel_q];
  assign wr_fire = s_valid & s_ready;
  assign rd_fire = m_valid & m_ready;

  // Next-state logic for the pointers, counters and full flags.
  // A write only targets a non-full bank, and a read only drains a full bank.
  // The set and the clear therefore never hit the same flag in one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first. This prevents a
    // latch on any path that does not assign it.
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_sel_d = rd_sel_q;
    rd_cnt_d = rd_cnt_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 4'd1;  // wraps 15 -> 0
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end

    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 4'd1;  // wraps 15 -> 0
      if (rd_cnt_q == 4'd15) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

`ifdef AES_SR_DUAL_DIR_EN
  // Each bank keeps its direction for the whole block. The direction is
  // latched when byte 0 of the block enters the bank.
  always_comb begin
    dir_d = dir_q;
    if (wr_fire && (wr_cnt_q == 4'd0)) begin
      dir_d[wr_sel_q] = enc;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      wr_cnt_q <= 4'd0;
      rd_sel_q <= 1'b0;
      rd_cnt_q <= 4'd0;
`ifdef AES_SR_DUAL_DIR_EN
      dir_q    <= 2'b00;
`endif
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_sel_q <= rd_sel_d;
      rd_cnt_q <= rd_cnt_d;
`ifdef AES_SR_DUAL_DIR_EN
      dir_q    <= dir_d;
`endif
    end
  end

  // NOTE: the bank storage has no reset. A bank is never read before its full
  // flag is set, so its stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_sel_q][wr_cnt_q] <= s_data;
    end
  end

  // Read-side address mapping. Output (col, row) fetches input column
  // col - row (inverse) or col + row (forward). The column arithmetic wraps
  // modulo 4 because it is 2 bits wide.
  always_comb begin
    rd_col = rd_cnt_q[3:2];
    rd_row = rd_cnt_q[1:0];
`ifdef AES_SR_DUAL_DIR_EN
    src_col = dir_q[rd_sel_q] ? (rd_col + rd_row) : (rd_col - rd_row);
`else
    src_col = rd_col - rd_row;
`endif
    rd_idx = {src_col, rd_row};
  end

  // The bank being read is full, so it cannot be written. Data therefore
  // stays stable during m_valid & !m_ready.
  assign m_data = m_valid ? bank_q[rd_sel_q][rd_idx] : 8'h00;
  assign m_last = m_valid & (rd_cnt_q == 4'd15);

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// -----------------------------------------------------------------------------
// tb_inv_shift_rows_serial
//
// Self-checking bench for inv_shift_rows_serial. The reference model keeps the
// accepted bytes of each block and arranges them as a 4x4 state matrix. It
// rotates row r right by r positions (left for the forward direction), then
// queues the result in column-major order. Each cycle the bench compares
// m_valid, s_ready, m_data and m_last against that model. Directed steps also
// compare the collected output blocks against literal expected vectors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_inv_shift_rows_serial;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
`ifdef AES_SR_DUAL_DIR_EN
  logic       enc;
`endif

  inv_shift_rows_serial dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
`ifdef AES_SR_DUAL_DIR_EN
    ,
    .enc     (enc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state.
  logic [7:0] exp_q [$];   // expected output bytes, in order
  logic [7:0] in_blk [$];  // bytes of the block currently arriving
  logic [7:0] got_q [$];   // output bytes actually handshaken
  logic       in_dir;      // 1 = forward mapping for the arriving block
  int         out_cnt;     // position within the current output block

  logic [7:0] lit_inv0  [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                  8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] lit_inv10 [16] = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                                  8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};
`ifdef AES_SR_DUAL_DIR_EN
  logic [7:0] lit_fwd0  [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                  8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Turn the completed block into a state matrix, rotate each row, and queue
  // the result in column-major order.
  task automatic push_block();
    logic [7:0] st [4][4];
    logic [7:0] tmp;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = in_blk[4*c + r];
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        if (in_dir) begin
          tmp = st[r][0];
          for (int c = 0; c < 3; c++) st[r][c] = st[r][c+1];
          st[r][3] = tmp;
        end else begin
          tmp = st[r][3];
          for (int c = 3; c > 0; c--) st[r][c] = st[r][c-1];
          st[r][0] = tmp;
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        exp_q.push_back(st[r][c]);
    in_blk.delete();
  endtask

  // One clock cycle. Drive the inputs, check the outputs against the model,
  // update the model for both handshakes, then advance to just after the edge.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    logic acc_in;
    logic acc_out;
    int   pending;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    pending = (exp_q.size() + 15) / 16;
    check("s_ready", s_ready, (pending < 2));
    check("m_valid", m_valid, (exp_q.size() != 0));
    if (m_valid) begin
      if (exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0]);
        check("m_last", m_last, (out_cnt == 15));
      end else begin
        check("spurious_valid", m_valid, 0);
      end
    end else begin
      check("idle_data", m_data, 8'h00);
      check("idle_last", m_last, 0);
    end
    acc_in  = sv & s_ready;
    acc_out = m_valid & mr;
    if (acc_out && exp_q.size() != 0) begin
      got_q.push_back(m_data);
      void'(exp_q.pop_front());
      out_cnt = (out_cnt + 1) % 16;
    end
    if (acc_in) begin
`ifdef AES_SR_DUAL_DIR_EN
      if (in_blk.size() == 0) in_dir = enc;
`endif
      in_blk.push_back(sd);
      if (in_blk.size() == 16) push_block();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step(1'b0, 8'($urandom), 1'b1);
      n++;
    end
    check("drain_done", (exp_q.size() == 0), 1);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    in_blk.delete();
    out_cnt = 0;
    in_dir  = 1'b0;
  endtask

  task automatic check_got(input string tag, input logic [7:0] lit [16]);
    check({tag, "_count"}, got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check(tag, got_q[i], lit[i]);
  endtask

  initial begin
    int idx;
    int sent;
    int n;
    logic a;
    logic sv;

    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    out_cnt = 0;
    in_dir  = 1'b0;
`ifdef AES_SR_DUAL_DIR_EN
    enc = 1'b0;
`endif
    do_reset();

    // Reset state.
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data,  8'h00);
    check("rst_m_last",  m_last,  0);

    // Single block 0x00..0x0F. Byte 0 must appear right after byte 15.
    got_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1);
    check("latency_valid", m_valid, 1);
    check("latency_byte0", m_data, 8'h00);
    drain(100);
    check_got("inv_block0", lit_inv0);

    // Three back-to-back blocks produce 48 contiguous output cycles.
    for (int i = 0; i < 64; i++) begin
      if (i < 48) check("b2b_ready", s_ready, 1);
      if (i >= 16) check("b2b_valid", m_valid, 1);
      step(i < 48, 8'($urandom), 1'b1);
    end
    check("b2b_idle", m_valid, 0);

    // Backpressure: two blocks fit, the third stalls.
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      a = s_ready;
      step(idx < 48, 8'(idx), 1'b0);
      if (a && idx < 48) idx++;
    end
    check("bp_accepted", idx, 32);
    check("bp_ready_low", s_ready, 0);
    check("bp_hold_data", m_data, 8'h00);
    for (int k = 0; k < 16; k++) begin
      check("bp_ready_wait", s_ready, 0);
      step(1'b1, 8'(idx), 1'b1);
    end
    check("bp_ready_rise", s_ready, 1);
    n = 0;
    while (idx < 48 && n < 200) begin
      a = s_ready;
      step(1'b1, 8'(idx), 1'b1);
      if (a) idx++;
      n++;
    end
    check("bp_third_sent", idx, 48);
    drain(200);

    // Random throttling over 100 random blocks.
    sent = 0;
    n    = 0;
    while (sent < 1600 && n < 20000) begin
      sv = 1'($urandom_range(0, 1));
      a  = sv & s_ready;
`ifdef AES_SR_DUAL_DIR_EN
      enc = 1'($urandom_range(0, 1));
`endif
      step(sv, 8'($urandom), 1'($urandom_range(0, 1)));
      if (a) sent++;
      n++;
    end
`ifdef AES_SR_DUAL_DIR_EN
    enc = 1'b0;
`endif
    check("rand_sent", sent, 1600);
    drain(200);

    // Reset after 7 bytes. Those 7 bytes must not leak into the next block.
    for (int i = 0; i < 7; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1);
    do_reset();
    check("rst2_s_ready", s_ready, 1);
    check("rst2_m_valid", m_valid, 0);
    check("rst2_m_data",  m_data,  8'h00);
    got_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b1);
    drain(100);
    check_got("inv_block10", lit_inv10);

`ifdef AES_SR_DUAL_DIR_EN
    // Forward direction.
    enc = 1'b1;
    got_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1);
    enc = 1'b0;
    drain(100);
    check_got("fwd_block0", lit_fwd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_serial.md
# inv_shift_rows_serial

Byte-serial AES InvShiftRows engine for the decryption datapath. Accepts a 128-bit state as 16 bytes in column-major order over a valid/ready stream, buffers each complete block in one of two ping-pong banks, and emits the inverse-row-shifted state as 16 bytes on an output stream. It sits between the byte-serial AddRoundKey/InvMixColumns stages of the iterative inverse cipher. It sustains one byte per cycle with a fixed one-block latency.

## Interface
- No parameters; byte width (8) and block size (16 bytes) are fixed by AES.

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- s_valid  input  1  input byte valid
- s_ready  output  1  engine can accept an input byte
- s_data  input  8  input byte
- m_valid  output  1  output byte valid
- m_ready  input  1  downstream accepts an output byte
- m_data  output  8  output byte
- m_last  output  1  high with output byte 15 of a block
- enc  input  1  present only with AES_SR_DUAL_DIR_EN; see Configuration

## Operation
- Byte index k = 0..15: column c = k/4, row r = k%4. Byte k corresponds to bits [31-8r -: 8] of state word w_c.
- Inverse mapping: output byte (c, r) = input byte at column (c - r) mod 4, row r, i.e. input index 4*((c-r) & 3) + r.
- Two banks, each 16 x 8 bits, with a full flag per bank. Write pointer wr_sel and 4-bit wr_cnt; read pointer rd_sel and 4-bit rd_cnt.
- Input handshake (s_valid & s_ready): write s_data to bank[wr_sel][wr_cnt] and increment wr_cnt. When wr_cnt = 15, set full[wr_sel], toggle wr_sel, and wrap wr_cnt to 0.
- s_ready = !full[wr_sel]. s_valid while s_ready is low has no effect.
- m_valid = full[rd_sel].
- m_data = bank[rd_sel][map(rd_cnt)] while m_valid; 0x00 otherwise.
- m_last = m_valid & (rd_cnt == 15).
- Output handshake (m_valid & m_ready): increment rd_cnt. When rd_cnt = 15, clear full[rd_sel], toggle rd_sel, and wrap rd_cnt to 0.
- A block completing on the write side and a bank releasing on the read side in the same cycle are independent; both flag updates apply.
- There is no combinational path from m_ready to s_ready or from s_valid to m_valid.

## Timing
- Reset values: s_ready = 1, m_valid = 0, m_data = 0x00, m_last = 0. Pointers, counters and full flags are 0. Bank contents are don't-care.
- Reset mid-block discards partial and buffered blocks; no output follows for them.
- Latency: if input byte 15 is accepted at edge N, m_valid is high in the cycle after edge N with output byte 0.
- With s_valid and m_ready held high, blocks stream back-to-back at 1 byte/cycle and s_ready never drops.
- When both banks are full, s_ready is low. It rises in the cycle after the edge where output byte 15 handshakes.
- While m_valid & !m_ready, m_data and m_last are held stable.

## Configuration
- AES_SR_DUAL_DIR_EN defined:
  - Adds the `enc` input and a 1-bit direction flag per bank. The flag is captured from `enc` when byte 0 of the block is accepted.
  - Flag = 1 selects the forward ShiftRows mapping: input index 4*((c+r) & 3) + r.
  - Flag = 0 selects the inverse mapping.
- AES_SR_DUAL_DIR_EN undefined: no `enc` port; the mapping is always inverse.

## Test plan
- Reset, then input bytes 0x00..0x0F with m_ready = 1 -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. m_last is high only on 0x03. m_valid first rises one cycle after byte 0x0F is accepted.
- Three back-to-back blocks with s_valid and m_ready held high -> 48 contiguous output cycles, s_ready constantly 1, each block correctly permuted.
- m_ready = 0 while three blocks are offered:
  - Two blocks are accepted, then s_ready = 0.
  - m_data holds 0x00 from block 0 stable.
  - After m_ready = 1 and 16 outputs, s_ready returns 1 the following cycle.
- Random s_valid/m_ready throttling (~50%) over 100 random blocks -> scoreboard matches the inverse mapping, with no lost or duplicated bytes.
- Reset asserted after 7 input bytes, then block 0x10..0x1F -> first output block is 10 1D 1A 17 14 11 1E 1B 18 15 12 1F 1C 19 16 13, with no residue from the first 7 bytes.
- With AES_SR_DUAL_DIR_EN, enc = 1 and input 0x00..0x0F -> output 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
